// File: rtl/s3_entry_sequencer.sv
// s3_entry_sequencer
// Upstream controller that produces the s3_state signal for the S3 system.
// It takes a software sleep request, waits for in-flight ALU work to drain,
// holds s3_state high while ALU and RAM save context, sleeps until a wake
// event, then runs a timed restore window before reporting ready.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - asynchronous, active-low reset
//   sleep_req    - level request to enter S3
//   wake_evt     - single-cycle or level wake event
//   alu_busy     - high while an ALU operation is in flight
//   wake_timeout - [15:0] sleep timer reload (only with S3_WAKE_TIMER_EN)
//   s3_state     - high in SAVE and SLEEP
//   sleep_ack    - high in SLEEP
//   ready        - high in RUN
//   abort_pulse  - one-cycle pulse when an entry gives up waiting for the ALU
//   seq_state    - current state (RUN=0 DRAIN=1 SAVE=2 SLEEP=3 RESTORE=4)
//   abort_cnt    - saturating count of aborted entries
//   sleep_cnt    - saturating count of SLEEP entries
//
// Optional feature macro: S3_WAKE_TIMER_EN adds the wake_timeout input and a
// down-counter that wakes the system from SLEEP on its own.

module s3_entry_sequencer #(
  parameter int DRAIN_MAX      = 16,
  parameter int SAVE_CYCLES    = 2,
  parameter int RESTORE_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sleep_req,
  input  logic             wake_evt,
  input  logic             alu_busy,
`ifdef S3_WAKE_TIMER_EN
  input  logic [15:0]      wake_timeout,
`endif
  output logic             s3_state,
  output logic             sleep_ack,
  output logic             ready,
  output logic             abort_pulse,
  output logic [2:0]       seq_state,
  output logic [CNT_W-1:0] abort_cnt,
  output logic [CNT_W-1:0] sleep_cnt
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_SAVE    = 3'd2,
    ST_SLEEP   = 3'd3,
    ST_RESTORE = 3'd4
  } state_e;

  // One shared phase counter serves DRAIN, SAVE and RESTORE, so it is sized
  // for the longest of the three windows.
  localparam int MAX_A = (DRAIN_MAX > SAVE_CYCLES) ? DRAIN_MAX : SAVE_CYCLES;
  localparam int MAX_C = (MAX_A > RESTORE_CYCLES) ? MAX_A : RESTORE_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0]    DRAIN_LAST   = CW'(DRAIN_MAX - 1);
  localparam logic [CW-1:0]    SAVE_LAST    = CW'(SAVE_CYCLES - 1);
  localparam logic [CW-1:0]    RESTORE_LAST = CW'(RESTORE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             wake_q, wake_d;
  logic             abort_pulse_q, abort_pulse_d;
  logic [CNT_W-1:0] abort_cnt_q, abort_cnt_d;
  logic [CNT_W-1:0] sleep_cnt_q, sleep_cnt_d;
  logic             wake_now;

`ifdef S3_WAKE_TIMER_EN
  logic [15:0]      timer_q, timer_d;
`endif

  // Next-state logic. Inputs are sampled into registers first, so every
  // decision acts on the value seen at the previous edge; this is what gives
  // the one-cycle request and wake latencies. In DRAIN the request drop beats
  // the busy drop, which in turn beats the abort timeout.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CW'(1);
    req_d         = sleep_req;
    busy_d        = alu_busy;
    wake_d        = wake_evt;
    abort_pulse_d = 1'b0;
    abort_cnt_d   = abort_cnt_q;
    sleep_cnt_d   = sleep_cnt_q;
    wake_now      = wake_q;
`ifdef S3_WAKE_TIMER_EN
    timer_d       = timer_q;
`endif

    case (state_q)
      ST_RUN: begin
        cnt_d = '0;
        if (req_q) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (!req_q) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (!busy_q) begin
          state_d = ST_SAVE;
          cnt_d   = '0;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d       = ST_RUN;
          cnt_d         = '0;
          abort_pulse_d = 1'b1;
          if (abort_cnt_q != CNT_MAX) begin
            abort_cnt_d = abort_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_SAVE: begin
        if (cnt_q == SAVE_LAST) begin
          state_d = ST_SLEEP;
          cnt_d   = '0;
          if (sleep_cnt_q != CNT_MAX) begin
            sleep_cnt_d = sleep_cnt_q + CNT_W'(1);
          end
`ifdef S3_WAKE_TIMER_EN
          timer_d = wake_timeout;
`endif
        end
      end

      ST_SLEEP: begin
        cnt_d = '0;
`ifdef S3_WAKE_TIMER_EN
        // A latched zero never counts, which keeps the timer disabled.
        if (timer_q != 16'd0) begin
          timer_d = timer_q - 16'd1;
          if (timer_q == 16'd1) begin
            wake_now = 1'b1;
          end
        end
`endif
        if (wake_now) begin
          state_d = ST_RESTORE;
        end
      end

      ST_RESTORE: begin
        if (cnt_q == RESTORE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers; reset drops straight back to RUN with no
  // restore window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      busy_q        <= 1'b0;
      wake_q        <= 1'b0;
      abort_pulse_q <= 1'b0;
      abort_cnt_q   <= '0;
      sleep_cnt_q   <= '0;
`ifdef S3_WAKE_TIMER_EN
      timer_q       <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      busy_q        <= busy_d;
      wake_q        <= wake_d;
      abort_pulse_q <= abort_pulse_d;
      abort_cnt_q   <= abort_cnt_d;
      sleep_cnt_q   <= sleep_cnt_d;
`ifdef S3_WAKE_TIMER_EN
      timer_q       <= timer_d;
`endif
    end
  end

  // Status outputs are pure decodes of the state register, so they follow
  // reset immediately and never glitch on input changes.
  always_comb begin
    s3_state    = (state_q == ST_SAVE) || (state_q == ST_SLEEP);
    sleep_ack   = (state_q == ST_SLEEP);
    ready       = (state_q == ST_RUN);
    seq_state   = state_q;
    abort_pulse = abort_pulse_q;
    abort_cnt   = abort_cnt_q;
    sleep_cnt   = sleep_cnt_q;
  end

endmodule

// File: doc/s3_entry_sequencer.md
# s3_entry_sequencer

Upstream controller that generates the `s3_state` signal consumed by the S3 system (ALU, RAM and power management). It accepts a software sleep request, drains in-flight ALU work, holds `s3_state` high so the ALU and RAM save their context, and keeps the system asleep until a wake event arrives. On wake it runs a timed restore window before it reports the system ready. It also counts aborted entries and completed sleep cycles for debug.

## Interface
Parameters:
- `DRAIN_MAX`, 16: maximum cycles spent waiting for `alu_busy` to drop before the entry is aborted.
- `SAVE_CYCLES`, 2: cycles `s3_state` is held before `sleep_ack` is asserted.
- `RESTORE_CYCLES`, 4: cycles from `s3_state` deassertion to `ready` assertion.
- `CNT_W`, 8: width of the debug counters.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `sleep_req` input 1: level request to enter S3.
- `wake_evt` input 1: single-cycle or level wake event.
- `alu_busy` input 1: high while an ALU operation is in flight.
- `s3_state` output 1: drives the `s3_state` input of the S3 system.
- `sleep_ack` output 1: high while the system is in SLEEP.
- `ready` output 1: system awake and usable.
- `abort_pulse` output 1: one-cycle pulse when an entry is aborted.
- `seq_state` output 3: current FSM state encoding.
- `abort_cnt` output CNT_W: number of aborted entries; saturates.
- `sleep_cnt` output CNT_W: number of completed SLEEP entries; saturates.

## Operation
- FSM states and encodings: RUN=0, DRAIN=1, SAVE=2, SLEEP=3, RESTORE=4.
- RUN to DRAIN: when `sleep_req` is 1. The drain counter clears to 0.
- DRAIN:
  - If `sleep_req` drops, return to RUN with no abort.
  - Otherwise, if `alu_busy` is 0, go to SAVE.
  - Otherwise, if the drain counter equals DRAIN_MAX-1, pulse `abort_pulse`, increment `abort_cnt`, and go to RUN.
  - Otherwise, increment the drain counter.
- SAVE: `s3_state` is 1. A counter runs SAVE_CYCLES cycles, then the FSM goes to SLEEP. `wake_evt` and `sleep_req` are ignored in SAVE.
- SLEEP:
  - `s3_state` and `sleep_ack` are 1.
  - On entry, `sleep_cnt` increments (saturating).
  - `wake_evt` goes to RESTORE.
  - Deassertion of `sleep_req` alone does not wake the system.
- RESTORE:
  - `s3_state` is 0.
  - After RESTORE_CYCLES cycles, go to RUN.
  - A `wake_evt` in RESTORE is ignored.
  - If `sleep_req` is still 1 on return to RUN, a new entry begins on the next cycle.
- `ready` is 1 only in RUN. Outputs are registered and decoded from the state register.
- Counters saturate at 2^CNT_W-1 and do not wrap.

## Timing
- Reset values:
  - State is RUN, so `ready` is 1.
  - `s3_state`, `sleep_ack` and `abort_pulse` are 0.
  - Both counters are 0.
  - `seq_state` is 0.
- Sleep latency: `sleep_req` sampled at edge N, with `alu_busy` 0, gives the following:
  - DRAIN at N+1.
  - SAVE at N+2, so `s3_state` rises at N+2.
  - SLEEP and `sleep_ack` at N+2+SAVE_CYCLES.
- Abort: with `alu_busy` held at 1, `abort_pulse` fires DRAIN_MAX cycles after DRAIN is entered.
- Wake latency: `wake_evt` at edge M in SLEEP gives the following:
  - `s3_state` falls at M+1.
  - `ready` rises at M+1+RESTORE_CYCLES.
- Simultaneous events:
  - `alu_busy` falling on the same cycle the drain counter expires goes to SAVE; the drop of busy has priority.
  - `sleep_req` deasserting on that same cycle returns the FSM to RUN; the request drop has highest priority.
- Reset mid-operation: the FSM returns to RUN immediately and asynchronously, and `s3_state` drops without a restore window.

## Configuration
- `S3_WAKE_TIMER_EN`: when defined, the block adds an input `wake_timeout` [15:0].
  - The value is latched on SAVE to SLEEP.
  - A down-counter runs in SLEEP. On reaching 0 it causes a wake exactly as `wake_evt` does.
  - If both fire in the same cycle, one RESTORE occurs.
  - A latched value of 0 disables the timer.
- Without the macro, there is no port and no counter, and only `wake_evt` wakes the system.

## Test plan
- Reset, then `sleep_req`=1 with `alu_busy`=0 and defaults:
  - `s3_state` rises 2 cycles after the request is sampled.
  - `sleep_ack` rises 2 cycles later.
  - `sleep_cnt`=1.
- In SLEEP, pulse `wake_evt` for 1 cycle:
  - `s3_state` falls the next cycle.
  - `ready` rises 4 cycles after that.
- Hold `alu_busy`=1 through DRAIN:
  - `abort_pulse` fires 16 cycles after DRAIN is entered.
  - `abort_cnt`=1.
  - `s3_state` never rises.
- Drop `alu_busy` on the same cycle the drain counter reaches 15: the FSM goes to SAVE, no abort occurs, and `abort_cnt` is unchanged.
- Assert `reset`=0 during SAVE: all outputs return to their reset values immediately, and `ready`=1 with no restore window.
- With `S3_WAKE_TIMER_EN` and `wake_timeout`=10:
  - The FSM exits SLEEP after 10 cycles with no `wake_evt`.
  - With `wake_timeout`=0, the FSM stays in SLEEP for 1000 cycles.
